// File: rtl/cg_cfg_spi.sv
// SPI mode-0 responder giving a host register access to the coilgun core.
// 32-bit frames: RW bit, 7-bit address, 24-bit data, MSB first.
module cg_cfg_spi #(
  parameter int unsigned DW          = 24,
  parameter int unsigned AW          = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          I_RST,
  input  logic          I_SCK,
  input  logic          I_CS_N,
  input  logic          I_MOSI,
  output logic          O_MISO,
  input  logic          I_RTE,
  input  logic [DW-1:0] I_ACC,
  output logic [DW-1:0] O_LMT,
  output logic [DW-1:0] O_DLY,
  output logic          O_OE,
  output logic          O_EN,
  output logic          O_DDS,
  output logic          O_LDS,
  output logic          O_LEN,
  output logic          O_WSTB,
  output logic          O_BUSY
);

  localparam int unsigned HW = AW + 1;
  localparam int unsigned FW = HW + DW;
  localparam int unsigned CW = $clog2(FW);

  localparam logic [AW-1:0] A_LMT  = AW'(0);
  localparam logic [AW-1:0] A_DLY  = AW'(1);
  localparam logic [AW-1:0] A_CTRL = AW'(2);
  localparam logic [AW-1:0] A_STAT = AW'(3);
  localparam logic [AW-1:0] A_ACC  = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_COMMIT,
    S_WAIT_CS
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                 sck_q;
  logic                 cs_q;
  logic                 sck_s;
  logic                 cs_s;
  logic                 mosi_s;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 cs_rise;
  logic                 cs_fall;
  logic [CW-1:0]        bit_cnt;
  logic [HW-1:0]        hdr;
  logic [HW-1:0]        hdr_next;
  logic [DW-1:0]        data_sr;
  logic [DW-1:0]        shift_out;
  logic [DW-1:0]        rd_val;
  logic                 rw_q;
  logic [AW-1:0]        addr_q;
  logic                 err;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign hdr_next = {hdr[HW-2:0], mosi_s};

  // Input synchronizers and previous-sample registers for edge detection.
  // CS_N resets to the "selected" level so a frame already running when
  // reset releases cannot look like a fresh CS_N fall; it must rise first.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], I_SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], I_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], I_MOSI};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  // Read-back value for the address completed by the current SCK rise.
  always_comb begin
    rd_val = '0;
    case (hdr_next[AW-1:0])
      A_LMT:   rd_val = O_LMT;
      A_DLY:   rd_val = O_DLY;
      A_CTRL:  rd_val = {{(DW-5){1'b0}}, O_LEN, O_LDS, O_DDS, O_EN, O_OE};
      A_STAT:  rd_val = {{(DW-2){1'b0}}, err, I_RTE};
      A_ACC:   rd_val = I_ACC;
      default: rd_val = '0;
    endcase
  end

  // Frame FSM: header/data shifting, MISO output, register commit.
  // Commit work is done in COMMIT even if CS_N rises that same cycle,
  // because all 32 bits were already received with CS_N low.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      hdr       <= '0;
      data_sr   <= '0;
      shift_out <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      err       <= 1'b0;
      O_MISO    <= 1'b0;
      O_LMT     <= '0;
      O_DLY     <= '0;
      O_OE      <= 1'b0;
      O_EN      <= 1'b0;
      O_DDS     <= 1'b0;
      O_LDS     <= 1'b0;
      O_LEN     <= 1'b0;
      O_WSTB    <= 1'b0;
      O_BUSY    <= 1'b0;
    end else begin
      O_WSTB <= 1'b0;
      case (state)
        S_IDLE: begin
          O_MISO <= 1'b0;
          if (cs_fall) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
            O_BUSY  <= 1'b1;
          end
        end
        S_ADDR: begin
          O_MISO <= 1'b0;
          if (sck_rise) begin
            hdr     <= hdr_next;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(HW-1)) begin
              state     <= S_DATA;
              rw_q      <= hdr_next[HW-1];
              addr_q    <= hdr_next[AW-1:0];
              shift_out <= hdr_next[HW-1] ? '0 : rd_val;
            end
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            O_MISO    <= shift_out[DW-1];
            shift_out <= {shift_out[DW-2:0], 1'b0};
          end
          if (sck_rise) begin
            data_sr <= {data_sr[DW-2:0], mosi_s};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(FW-1)) begin
              state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          O_MISO <= 1'b0;
          state  <= S_WAIT_CS;
          if (rw_q) begin
            if (addr_q == A_LMT || addr_q == A_DLY) begin
              if (O_EN) begin
                err <= 1'b1;
              end else begin
                if (addr_q == A_LMT) O_LMT <= data_sr;
                else                 O_DLY <= data_sr;
                O_WSTB <= 1'b1;
              end
            end else if (addr_q == A_CTRL) begin
              {O_LEN, O_LDS, O_DDS, O_EN, O_OE} <= data_sr[4:0];
              O_WSTB <= 1'b1;
            end
          end else if (addr_q == A_STAT) begin
            err <= 1'b0;
          end
        end
        S_WAIT_CS: begin
          O_MISO <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          O_MISO <= 1'b0;
        end
      endcase
      if (cs_rise) begin
        state  <= S_IDLE;
        O_MISO <= 1'b0;
        O_BUSY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cg_cfg_spi.sv
// Bench for cg_cfg_spi: directed SPI frames against a register-level model.
module tb_cg_cfg_spi;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        I_RST, I_SCK, I_CS_N, I_MOSI, O_MISO, I_RTE;
  logic [23:0] I_ACC, O_LMT, O_DLY;
  logic        O_OE, O_EN, O_DDS, O_LDS, O_LEN, O_WSTB, O_BUSY;

  int   checks = 0;
  int   errors = 0;
  int   wstb_seen = 0;
  logic wstb_prev = 1'b0;
  bit   chk_en = 1'b0;

  logic [23:0] m_lmt = '0, m_dly = '0;
  logic [4:0]  m_ctrl = '0;
  logic        m_err = 1'b0;

  cg_cfg_spi #(.DW(24), .AW(7), .SYNC_STAGES(2)) dut (
    .clk(clk), .I_RST(I_RST), .I_SCK(I_SCK), .I_CS_N(I_CS_N), .I_MOSI(I_MOSI),
    .O_MISO(O_MISO), .I_RTE(I_RTE), .I_ACC(I_ACC), .O_LMT(O_LMT), .O_DLY(O_DLY),
    .O_OE(O_OE), .O_EN(O_EN), .O_DDS(O_DDS), .O_LDS(O_LDS), .O_LEN(O_LEN),
    .O_WSTB(O_WSTB), .O_BUSY(O_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-level model: effect of one complete frame and its read data.
  task automatic model_frame(input logic [31:0] tx, input logic [23:0] acc, input logic rte,
                             output logic [31:0] exp_rx, output int exp_w);
    logic [6:0]  a;
    logic [23:0] d;
    a = tx[30:24];
    d = tx[23:0];
    exp_rx = '0;
    exp_w  = 0;
    if (tx[31]) begin
      if (a == 7'd0 || a == 7'd1) begin
        if (m_ctrl[1]) m_err = 1'b1;
        else begin
          if (a == 7'd0) m_lmt = d; else m_dly = d;
          exp_w = 1;
        end
      end else if (a == 7'd2) begin
        m_ctrl = d[4:0];
        exp_w  = 1;
      end
    end else begin
      case (a)
        7'd0: exp_rx = {8'h0, m_lmt};
        7'd1: exp_rx = {8'h0, m_dly};
        7'd2: exp_rx = {27'h0, m_ctrl};
        7'd3: begin exp_rx = {30'h0, m_err, rte}; m_err = 1'b0; end
        7'd4: exp_rx = {8'h0, acc};
        default: exp_rx = '0;
      endcase
    end
  endtask

  // Host side of one mode-0 transfer; MISO sampled just before each rise.
  task automatic spi_xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    I_CS_N = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      I_MOSI = (i < 32) ? tx[31-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 32) rx[31-i] = O_MISO;
      if (i == 4) check("busy_in_frame", {31'h0, O_BUSY}, 32'd1);
      I_SCK = 1'b1;
      repeat (HALF) @(negedge clk);
      I_SCK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    I_CS_N = 1'b1;
    I_MOSI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input logic [31:0] tx, input int nbits, input bit acc_chg,
                          output logic [31:0] rx);
    logic [31:0] exp_rx;
    int exp_w, w0;
    chk_en = 1'b0;
    w0 = wstb_seen;
    model_frame(tx, I_ACC, I_RTE, exp_rx, exp_w);
    fork
      spi_xfer(tx, nbits, rx);
      begin
        if (acc_chg) begin
          repeat (HALF + 2*HALF*12) @(negedge clk);
          I_ACC = 24'hABCDEF;
        end
      end
    join
    if (!tx[31]) check($sformatf("read_a%02h", tx[30:24]), rx, exp_rx);
    check($sformatf("wstb_count_%08h", tx), wstb_seen - w0, exp_w);
    chk_en = 1'b1;
  endtask

  // Continuous comparison of the register outputs against the model.
  always @(negedge clk) begin
    if (O_WSTB === 1'b1) begin
      wstb_seen++;
      check("wstb_single_cycle", {31'h0, wstb_prev}, 32'd0);
    end
    wstb_prev = O_WSTB;
    if (chk_en) begin
      check("lmt", {8'h0, O_LMT}, {8'h0, m_lmt});
      check("dly", {8'h0, O_DLY}, {8'h0, m_dly});
      check("ctrl", {27'h0, O_LEN, O_LDS, O_DDS, O_EN, O_OE}, {27'h0, m_ctrl});
      check("busy_idle", {31'h0, O_BUSY}, 32'd0);
      check("miso_idle", {31'h0, O_MISO}, 32'd0);
    end
  end

  logic [31:0] rx;
  int          w0;

  initial begin
    I_RST = 1'b1; I_SCK = 1'b0; I_CS_N = 1'b1; I_MOSI = 1'b0;
    I_RTE = 1'b0; I_ACC = '0;
    repeat (3) @(negedge clk);
    check("rst_lmt", {8'h0, O_LMT}, 32'd0);
    check("rst_dly", {8'h0, O_DLY}, 32'd0);
    check("rst_ctrl", {27'h0, O_LEN, O_LDS, O_DDS, O_EN, O_OE}, 32'd0);
    check("rst_misc", {29'h0, O_MISO, O_WSTB, O_BUSY}, 32'd0);
    I_RST = 1'b0;
    repeat (10) @(negedge clk);
    chk_en = 1'b1;

    // 1: basic LMT write
    do_frame(32'h80000014, 32, 1'b0, rx);
    check("lit_lmt20", {8'h0, O_LMT}, 32'd20);

    // 2: DLY write and read-back, unused address, STATUS write ignored
    do_frame(32'h8100000A, 32, 1'b0, rx);
    do_frame(32'h01000000, 32, 1'b0, rx);
    check("lit_rd_dly", rx, 32'h0000000A);
    check("lit_dly10", {8'h0, O_DLY}, 32'd10);
    do_frame(32'hFF00ABCD, 32, 1'b0, rx);
    do_frame(32'h7F000000, 32, 1'b0, rx);
    do_frame(32'h83000003, 32, 1'b0, rx);
    do_frame(32'h00000000, 32, 1'b0, rx);

    // 3: arming lock and ERR clear-on-read
    do_frame(32'h8200001F, 32, 1'b0, rx);
    check("lit_ctrl1f", {27'h0, O_LEN, O_LDS, O_DDS, O_EN, O_OE}, 32'h1F);
    do_frame(32'h80000063, 32, 1'b0, rx);
    check("lit_lmt_locked", {8'h0, O_LMT}, 32'd20);
    do_frame(32'h03000000, 32, 1'b0, rx);
    check("lit_stat_err", rx, 32'h00000002);
    do_frame(32'h03000000, 32, 1'b0, rx);
    check("lit_stat_clr", rx, 32'h00000000);

    // 4: aborted frame then recovery
    chk_en = 1'b0;
    w0 = wstb_seen;
    spi_xfer(32'h80000005, 20, rx);
    check("abort_wstb", wstb_seen - w0, 32'd0);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    do_frame(32'h82000000, 32, 1'b0, rx);
    do_frame(32'h80000005, 32, 1'b0, rx);
    check("lit_lmt5", {8'h0, O_LMT}, 32'd5);

    // 5: ACC snapshot stability and STATUS RTE
    I_ACC = 24'h123456;
    I_RTE = 1'b1;
    do_frame(32'h04000000, 32, 1'b1, rx);
    check("lit_rd_acc", rx, 32'h00123456);
    do_frame(32'h03000000, 32, 1'b0, rx);
    check("lit_rd_stat", rx, 32'h00000001);

    // 6: reset mid-write, then an overrun frame
    do_frame(32'h82000015, 32, 1'b0, rx);
    chk_en = 1'b0;
    w0 = wstb_seen;
    fork
      spi_xfer(32'h80000007, 32, rx);
      begin
        repeat (HALF + 2*HALF*16) @(negedge clk);
        I_RST = 1'b1;
        #1;
        check("midrst_lmt", {8'h0, O_LMT}, 32'd0);
        check("midrst_dly", {8'h0, O_DLY}, 32'd0);
        check("midrst_ctrl", {27'h0, O_LEN, O_LDS, O_DDS, O_EN, O_OE}, 32'd0);
        check("midrst_misc", {29'h0, O_MISO, O_WSTB, O_BUSY}, 32'd0);
        m_lmt = '0; m_dly = '0; m_ctrl = '0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        I_RST = 1'b0;
      end
    join
    check("postrst_wstb", wstb_seen - w0, 32'd0);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    do_frame(32'h80000033, 40, 1'b0, rx);
    check("lit_lmt_overrun", {8'h0, O_LMT}, 32'h33);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
